// File: rtl/touch_pkg.sv
// Shared encodings for the touch-key LED controller.
package touch_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_FLOW   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    // Key meaning is fixed by index.
    localparam int KEY_PWR  = 0;
    localparam int KEY_MODE = 1;
    localparam int KEY_UP   = 2;
    localparam int KEY_DN   = 3;

    // Pattern load values on mode entry.
    localparam logic [3:0] FLOW_LOAD  = 4'b0001;
    localparam logic [3:0] BLINK_LOAD = 4'b1111;

    // Rotate a 4-bit LED pattern left with wrap (1000 -> 0001).
    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/touch_debounce.sv
// One touch key: 2-FF synchroniser, stability counter and press pulse.
// Pads idle high, so everything resets to the released level.
module touch_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_evt
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pad level into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed from the stable level
    // for DEB_CNT consecutive cycles; pulse on an accepted press (1->0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable  <= 1'b1;
            cnt     <= '0;
            key_evt <= 1'b0;
        end else begin
            key_evt <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CNT - 1)) begin
                stable  <= sync2;
                cnt     <= '0;
                key_evt <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/touch_led_ctrl.sv
// Touch-key front end: debounce, press arbitration, LED mode FSM,
// animation tick timer and LED pattern register.
module touch_led_ctrl
    import touch_pkg::*;
#(
    parameter int NKEY     = 4,
    parameter int DEB_CNT  = 1_000_000,
    parameter int TICK_CNT = 25_000_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [NKEY-1:0] touch_key,
    output logic [3:0]      led_out,
    output logic [1:0]      mode,
    output logic [1:0]      speed,
    output logic [NKEY-1:0] key_evt
);

    localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

    // ---------------- per-key debounce ----------------
    for (genvar i = 0; i < NKEY; i++) begin : g_key
        touch_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk     (sys_clk),
            .rst     (sys_rst),
            .key_raw (touch_key[i]),
            .key_evt (key_evt[i])
        );
    end

    // ---------------- arbitration ----------------
    logic [NKEY-1:0] pending;
    logic [NKEY-1:0] req;
    logic [NKEY-1:0] grant;

    assign req   = pending | key_evt;
    assign grant = req & (~req + NKEY'(1));   // isolate lowest set bit

    // Presses not granted this cycle wait their turn in index order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) pending <= '0;
        else         pending <= req & ~grant;
    end

    // ---------------- mode / speed FSM ----------------
    mode_t      mode_q, mode_nxt;
    mode_t      rem_q, rem_nxt;
    logic [1:0] speed_q, speed_nxt;

    // State register; the power key returns to the remembered mode.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q  <= MODE_OFF;
            rem_q   <= MODE_STATIC;
            speed_q <= 2'd0;
        end else begin
            mode_q  <= mode_nxt;
            rem_q   <= rem_nxt;
            speed_q <= speed_nxt;
        end
    end

    // Next state from the single granted key.
    always_comb begin
        mode_nxt  = mode_q;
        rem_nxt   = rem_q;
        speed_nxt = speed_q;
        if (grant[KEY_PWR]) begin
            if (mode_q == MODE_OFF) begin
                mode_nxt = rem_q;
            end else begin
                mode_nxt = MODE_OFF;
                rem_nxt  = mode_q;
            end
        end else if (grant[KEY_MODE]) begin
            case (mode_q)
                MODE_STATIC: mode_nxt = MODE_FLOW;
                MODE_FLOW:   mode_nxt = MODE_BLINK;
                MODE_BLINK:  mode_nxt = MODE_STATIC;
                default:     mode_nxt = mode_q;
            endcase
        end else if (grant[KEY_UP]) begin
            if (speed_q != 2'd3) speed_nxt = speed_q + 2'd1;
        end else if (grant[KEY_DN]) begin
            if (speed_q != 2'd0) speed_nxt = speed_q - 2'd1;
        end
    end

    // ---------------- animation tick ----------------
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_max;
    logic          running;
    logic          changed;
    logic          tick;

    assign tick_max = TW'((TICK_CNT >> speed_q) - 1);
    assign running  = (mode_q == MODE_FLOW) || (mode_q == MODE_BLINK);
    assign changed  = (mode_nxt != mode_q) || (speed_nxt != speed_q);
    assign tick     = running && (tick_cnt == tick_max);

    // Free-running period counter, restarted on every mode/speed change.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                 tick_cnt <= '0;
        else if (changed || !running) tick_cnt <= '0;
        else if (tick)               tick_cnt <= '0;
        else                         tick_cnt <= tick_cnt + TW'(1);
    end

    // ---------------- LED pattern ----------------
    logic [3:0] led_q;
    mode_t      mode_d;   // mode seen last cycle, to detect entry

    // Load on mode entry, then animate on ticks.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_q  <= 4'b0000;
            mode_d <= MODE_OFF;
        end else begin
            mode_d <= mode_q;
            case (mode_q)
                MODE_OFF:    led_q <= 4'b0000;
                MODE_STATIC: led_q <= 4'b1111;
                MODE_FLOW: begin
                    if (mode_d != MODE_FLOW) led_q <= FLOW_LOAD;
                    else if (tick)           led_q <= rotl4(led_q);
                end
                MODE_BLINK: begin
                    if (mode_d != MODE_BLINK) led_q <= BLINK_LOAD;
                    else if (tick)            led_q <= ~led_q;
                end
                default:     led_q <= 4'b0000;
            endcase
        end
    end

    assign led_out = led_q;
    assign mode    = mode_q;
    assign speed   = speed_q;

endmodule
